// File: rtl/hls_cfg_pkg.sv
// Shared definitions for the HLS accelerator configuration master: register map,
// control-register bit positions, AXI response codes and the sequencer state encoding.
package hls_cfg_pkg;

    typedef enum logic [7:0] {
        ADDR_AP_CTRL = 8'h00,
        ADDR_GIE     = 8'h04,
        ADDR_IER     = 8'h08,
        ADDR_ISR     = 8'h0C
    } reg_addr_e;

    typedef enum int {
        AP_START = 0,
        AP_DONE  = 1,
        AP_IDLE  = 2
    } ap_bit_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WAIT_IRQ,
        ST_FIN
    } state_e;

    // Anything other than OKAY is treated as a failed transfer.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/hls_config_master_xfer.sv
// axil_single_xfer: performs exactly one AXI4-Lite read or write per req pulse.
// VALIDs are registered and only ever cleared by their own handshake.
module axil_single_xfer #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req,
    input  logic                      we,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    output logic                      addr_done,
    output logic                      ack,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                resp,
    output logic                      axi_awvalid,
    input  logic                      axi_awready,
    output logic [ADDR_WIDTH-1:0]     axi_awaddr,
    output logic                      axi_wvalid,
    input  logic                      axi_wready,
    output logic [DATA_WIDTH-1:0]     axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   axi_wstrb,
    input  logic                      axi_bvalid,
    output logic                      axi_bready,
    input  logic [1:0]                axi_bresp,
    output logic                      axi_arvalid,
    input  logic                      axi_arready,
    output logic [ADDR_WIDTH-1:0]     axi_araddr,
    input  logic                      axi_rvalid,
    output logic                      axi_rready,
    input  logic [DATA_WIDTH-1:0]     axi_rdata,
    input  logic [1:0]                axi_rresp
);

    logic                  aw_vld_q, aw_vld_d;
    logic                  w_vld_q, w_vld_d;
    logic                  ar_vld_q, ar_vld_d;
    logic                  bready_q, bready_d;
    logic                  rready_q, rready_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    always_comb begin
        aw_vld_d  = aw_vld_q;
        w_vld_d   = w_vld_q;
        ar_vld_d  = ar_vld_q;
        bready_d  = bready_q;
        rready_d  = rready_q;
        awaddr_d  = awaddr_q;
        araddr_d  = araddr_q;
        wdata_d   = wdata_q;
        addr_done = 1'b0;

        if (aw_vld_q && axi_awready) aw_vld_d = 1'b0;
        if (w_vld_q && axi_wready)   w_vld_d  = 1'b0;
        // AW and W may complete in either order; the response phase opens once both have.
        if ((aw_vld_q || w_vld_q) && !aw_vld_d && !w_vld_d) begin
            bready_d  = 1'b1;
            addr_done = 1'b1;
        end
        if (ar_vld_q && axi_arready) begin
            ar_vld_d  = 1'b0;
            rready_d  = 1'b1;
            addr_done = 1'b1;
        end
        if (bready_q && axi_bvalid) bready_d = 1'b0;
        if (rready_q && axi_rvalid) rready_d = 1'b0;

        if (req) begin
            if (we) begin
                aw_vld_d = 1'b1;
                w_vld_d  = 1'b1;
                awaddr_d = addr;
                wdata_d  = wdata;
            end else begin
                ar_vld_d = 1'b1;
                araddr_d = addr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_vld_q <= 1'b0;
            w_vld_q  <= 1'b0;
            ar_vld_q <= 1'b0;
            bready_q <= 1'b0;
            rready_q <= 1'b0;
            awaddr_q <= '0;
            araddr_q <= '0;
            wdata_q  <= '0;
        end else begin
            aw_vld_q <= aw_vld_d;
            w_vld_q  <= w_vld_d;
            ar_vld_q <= ar_vld_d;
            bready_q <= bready_d;
            rready_q <= rready_d;
            awaddr_q <= awaddr_d;
            araddr_q <= araddr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign ack   = (bready_q && axi_bvalid) || (rready_q && axi_rvalid);
    assign rdata = axi_rdata;
    assign resp  = rready_q ? axi_rresp : axi_bresp;

    assign axi_awvalid = aw_vld_q;
    assign axi_awaddr  = awaddr_q;
    assign axi_wvalid  = w_vld_q;
    assign axi_wdata   = wdata_q;
    assign axi_wstrb   = {(DATA_WIDTH/8){w_vld_q}};
    assign axi_bready  = bready_q;
    assign axi_arvalid = ar_vld_q;
    assign axi_araddr  = araddr_q;
    assign axi_rready  = rready_q;

endmodule

// File: rtl/hls_config_master.sv
// Starts one hls_target invocation per cmd_start (ap_start write), then polls ap_done.
// Define HLS_CFG_IRQ_EN to enable GIE/IER setup and interrupt-driven completion instead.
module hls_config_master
    import hls_cfg_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int POLL_LIMIT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_start,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [DATA_WIDTH-1:0]   status,
    output logic [15:0]             poll_count,
    input  logic                    interrupt,
    output logic                    m_axi_config_AWVALID,
    input  logic                    m_axi_config_AWREADY,
    output logic [ADDR_WIDTH-1:0]   m_axi_config_AWADDR,
    output logic                    m_axi_config_WVALID,
    input  logic                    m_axi_config_WREADY,
    output logic [DATA_WIDTH-1:0]   m_axi_config_WDATA,
    output logic [DATA_WIDTH/8-1:0] m_axi_config_WSTRB,
    input  logic                    m_axi_config_BVALID,
    output logic                    m_axi_config_BREADY,
    input  logic [1:0]              m_axi_config_BRESP,
    output logic                    m_axi_config_ARVALID,
    input  logic                    m_axi_config_ARREADY,
    output logic [ADDR_WIDTH-1:0]   m_axi_config_ARADDR,
    input  logic                    m_axi_config_RVALID,
    output logic                    m_axi_config_RREADY,
    input  logic [DATA_WIDTH-1:0]   m_axi_config_RDATA,
    input  logic [1:0]              m_axi_config_RRESP
);

    localparam logic [ADDR_WIDTH-1:0] A_CTRL     = ADDR_WIDTH'(ADDR_AP_CTRL);
    localparam logic [DATA_WIDTH-1:0] START_WORD = DATA_WIDTH'(1) << AP_START;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_e                state_q, state_d;
    logic                  error_q, error_d;
    logic [DATA_WIDTH-1:0] status_q, status_d;
    logic [15:0]           poll_q, poll_d;

    logic                  req, req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  addr_done, ack;
    logic [DATA_WIDTH-1:0] xfer_rdata;
    logic [1:0]            xfer_resp;

`ifdef HLS_CFG_IRQ_EN
    localparam logic [ADDR_WIDTH-1:0] A_GIE    = ADDR_WIDTH'(ADDR_GIE);
    localparam logic [ADDR_WIDTH-1:0] A_IER    = ADDR_WIDTH'(ADDR_IER);
    localparam logic [ADDR_WIDTH-1:0] A_ISR    = ADDR_WIDTH'(ADDR_ISR);
    localparam logic [DATA_WIDTH-1:0] ONE_WORD = DATA_WIDTH'(1);
    localparam logic [1:0] SEL_GIE = 2'd0, SEL_IER = 2'd1, SEL_START = 2'd2, SEL_ISR = 2'd3;
    // Which write is outstanding, so WR_RESP knows what comes next.
    logic [1:0] wr_sel_q, wr_sel_d;
`else
    logic unused_interrupt;
    assign unused_interrupt = interrupt;
`endif

    always_comb begin
        state_d   = state_q;
        error_d   = error_q;
        status_d  = status_q;
        poll_d    = poll_q;
        req       = 1'b0;
        req_we    = 1'b0;
        req_addr  = A_CTRL;
        req_wdata = '0;
`ifdef HLS_CFG_IRQ_EN
        wr_sel_d  = wr_sel_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_start) begin
                    error_d = 1'b0;
                    poll_d  = '0;
                    req     = 1'b1;
                    req_we  = 1'b1;
                    state_d = ST_WR;
`ifdef HLS_CFG_IRQ_EN
                    req_addr  = A_GIE;
                    req_wdata = ONE_WORD;
                    wr_sel_d  = SEL_GIE;
`else
                    req_wdata = START_WORD;
`endif
                end
            end
            ST_WR: if (addr_done) state_d = ST_WR_RESP;
            ST_WR_RESP: begin
                if (ack) begin
                    if (resp_is_err(xfer_resp)) begin
                        error_d = 1'b1;
                        state_d = ST_FIN;
                    end else begin
`ifdef HLS_CFG_IRQ_EN
                        case (wr_sel_q)
                            SEL_GIE: begin
                                req = 1'b1; req_we = 1'b1; req_addr = A_IER;
                                req_wdata = ONE_WORD; wr_sel_d = SEL_IER; state_d = ST_WR;
                            end
                            SEL_IER: begin
                                req = 1'b1; req_we = 1'b1; req_addr = A_CTRL;
                                req_wdata = START_WORD; wr_sel_d = SEL_START; state_d = ST_WR;
                            end
                            SEL_START: state_d = ST_WAIT_IRQ;
                            default:   state_d = ST_FIN;
                        endcase
`else
                        req     = 1'b1;
                        poll_d  = sat_inc(poll_q);
                        state_d = ST_RD_ADDR;
`endif
                    end
                end
            end
`ifdef HLS_CFG_IRQ_EN
            ST_WAIT_IRQ: begin
                if (interrupt) begin
                    req     = 1'b1;
                    poll_d  = sat_inc(poll_q);
                    state_d = ST_RD_ADDR;
                end
            end
`endif
            ST_RD_ADDR: if (addr_done) state_d = ST_RD_DATA;
            ST_RD_DATA: begin
                if (ack) begin
                    status_d = xfer_rdata;
                    if (resp_is_err(xfer_resp)) begin
                        error_d = 1'b1;
                        state_d = ST_FIN;
                    end else begin
`ifdef HLS_CFG_IRQ_EN
                        req = 1'b1; req_we = 1'b1; req_addr = A_ISR;
                        req_wdata = ONE_WORD; wr_sel_d = SEL_ISR; state_d = ST_WR;
`else
                        if (xfer_rdata[AP_DONE]) begin
                            state_d = ST_FIN;
                        end else if (poll_q == 16'(POLL_LIMIT)) begin
                            error_d = 1'b1;
                            state_d = ST_FIN;
                        end else begin
                            req     = 1'b1;
                            poll_d  = sat_inc(poll_q);
                            state_d = ST_RD_ADDR;
                        end
`endif
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            error_q  <= 1'b0;
            status_q <= '0;
            poll_q   <= '0;
        end else begin
            state_q  <= state_d;
            error_q  <= error_d;
            status_q <= status_d;
            poll_q   <= poll_d;
        end
    end

`ifdef HLS_CFG_IRQ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wr_sel_q <= SEL_GIE;
        else     wr_sel_q <= wr_sel_d;
    end
`endif

    axil_single_xfer #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_xfer (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .we          (req_we),
        .addr        (req_addr),
        .wdata       (req_wdata),
        .addr_done   (addr_done),
        .ack         (ack),
        .rdata       (xfer_rdata),
        .resp        (xfer_resp),
        .axi_awvalid (m_axi_config_AWVALID),
        .axi_awready (m_axi_config_AWREADY),
        .axi_awaddr  (m_axi_config_AWADDR),
        .axi_wvalid  (m_axi_config_WVALID),
        .axi_wready  (m_axi_config_WREADY),
        .axi_wdata   (m_axi_config_WDATA),
        .axi_wstrb   (m_axi_config_WSTRB),
        .axi_bvalid  (m_axi_config_BVALID),
        .axi_bready  (m_axi_config_BREADY),
        .axi_bresp   (m_axi_config_BRESP),
        .axi_arvalid (m_axi_config_ARVALID),
        .axi_arready (m_axi_config_ARREADY),
        .axi_araddr  (m_axi_config_ARADDR),
        .axi_rvalid  (m_axi_config_RVALID),
        .axi_rready  (m_axi_config_RREADY),
        .axi_rdata   (m_axi_config_RDATA),
        .axi_rresp   (m_axi_config_RRESP)
    );

    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_FIN);
    assign error      = error_q;
    assign status     = status_q;
    assign poll_count = poll_q;

endmodule
